// File: rtl/booth_ctrl.sv
// -----------------------------------------------------------------------------
// booth_ctrl
// Sequencing controller for a radix-2 Booth multiplier datapath.
//
// A request on `start` (accepted only while idle) loads both operands and
// clears the accumulator. WIDTH_M evaluate/shift iterations follow, steering
// add/subtract from the multiplier's low bit pair. Finally the final-product
// register is enabled and held enabled until the next request is accepted.
//
// Optional feature macro: BOOTH_SKIP_EN
//   When defined, iterations whose bit pair is 2'b00 or 2'b11 skip the EVAL
//   cycle, going SHIFT->SHIFT (or LOAD->SHIFT). The datapath must present the
//   next pair on q0_q1 during LOAD and SHIFT. Latency becomes data dependent:
//   WIDTH_M+2 .. 2*WIDTH_M+2 cycles. When undefined, every iteration takes one
//   EVAL and one SHIFT cycle.
//
// Parameters
//   WIDTH_M  : operand width and Booth iteration count (>= 2)
//
// Ports
//   clk      : clock, rising edge active
//   reset    : synchronous active-high reset
//   start    : multiply request, sampled only in IDLE
//   q0_q1    : {Q0, Q-1} from the datapath multiplier register
//   ld_a     : load multiplicand register
//   ld_b     : load multiplier register and clear Q-1
//   clr_acc  : clear accumulator
//   add_en   : accumulator += multiplicand
//   sub_en   : accumulator -= multiplicand
//   shift_en : arithmetic shift right of {acc, Q, Q-1}
//   en_fp    : final-product register enable (held high to keep the result)
//   busy     : high whenever the controller is not idle
//   done     : one-cycle completion pulse
// -----------------------------------------------------------------------------
module booth_ctrl #(
   parameter int WIDTH_M = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] q0_q1,
   output logic       ld_a,
   output logic       ld_b,
   output logic       clr_acc,
   output logic       add_en,
   output logic       sub_en,
   output logic       shift_en,
   output logic       en_fp,
   output logic       busy,
   output logic       done
);

   localparam int                CNT_W    = $clog2(WIDTH_M + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH_M);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EVAL  = 3'd2,
      S_SHIFT = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             vld;
   logic             vld_nxt;

`ifdef BOOTH_SKIP_EN
   // Equal bits in the pair mean neither add nor subtract: EVAL can be skipped.
   logic pair_nop;
   assign pair_nop = (q0_q1[1] == q0_q1[0]);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         vld   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         vld   <= vld_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      vld_nxt   = vld;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      clr_acc   = 1'b0;
      add_en    = 1'b0;
      sub_en    = 1'b0;
      shift_en  = 1'b0;
      en_fp     = 1'b0;
      done      = 1'b0;

      case (state)
         S_IDLE: begin
            // Keep the product register enabled while a result is held.
            en_fp = vld;
            if (start) begin
               state_nxt = S_LOAD;
            end
         end

         S_LOAD: begin
            ld_a    = 1'b1;
            ld_b    = 1'b1;
            clr_acc = 1'b1;
            cnt_nxt = CNT_LOAD;
            // Dropping vld drops en_fp, which clears the product register.
            vld_nxt = 1'b0;
`ifdef BOOTH_SKIP_EN
            state_nxt = pair_nop ? S_SHIFT : S_EVAL;
`else
            state_nxt = S_EVAL;
`endif
         end

         S_EVAL: begin
            add_en    = (q0_q1 == 2'b01);
            sub_en    = (q0_q1 == 2'b10);
            state_nxt = S_SHIFT;
         end

         S_SHIFT: begin
            shift_en = 1'b1;
            cnt_nxt  = cnt - CNT_ONE;
            // "<=" rather than "==" so a corrupted zero count still terminates.
            if (cnt <= CNT_ONE) begin
               state_nxt = S_FIN;
`ifdef BOOTH_SKIP_EN
            end else if (pair_nop) begin
               state_nxt = S_SHIFT;
`endif
            end else begin
               state_nxt = S_EVAL;
            end
         end

         S_FIN: begin
            en_fp     = 1'b1;
            done      = 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_booth_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_ctrl
// Bench for booth_ctrl with WIDTH_M = 8. A small Booth datapath is attached so
// real products can be formed; q0_q1 can instead be tied or alternated.
// Expected per-operation results go into a queue when a request is issued; a
// monitor process pops them whenever the controller signals done.
// Works with or without BOOTH_SKIP_EN defined.
// -----------------------------------------------------------------------------
module tb_booth_ctrl;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] q0_q1;
   logic       ld_a, ld_b, clr_acc, add_en, sub_en, shift_en, en_fp, busy, done;

   booth_ctrl #(.WIDTH_M(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .q0_q1    (q0_q1),
      .ld_a     (ld_a),
      .ld_b     (ld_b),
      .clr_acc  (clr_acc),
      .add_en   (add_en),
      .sub_en   (sub_en),
      .shift_en (shift_en),
      .en_fp    (en_fp),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   logic [8:0] outs;
   assign outs = {ld_a, ld_b, clr_acc, add_en, sub_en, shift_en, en_fp, busy, done};

   // Attached Booth datapath (accumulator one bit wider so -2^(W-1) works)
   logic        [W-1:0]   a_in, b_in;
   logic signed [W-1:0]   m_reg;
   logic signed [W-1:0]   q_reg;
   logic signed [W:0]     acc;
   logic                  q_1;
   logic        [2*W-1:0] fp;

   always_ff @(posedge clk) begin
      if (ld_a) m_reg <= a_in;
      if (clr_acc)       acc <= '0;
      else if (add_en)   acc <= acc + {m_reg[W-1], m_reg};
      else if (sub_en)   acc <= acc - {m_reg[W-1], m_reg};
      else if (shift_en) acc <= {acc[W], acc[W:1]};
      if (ld_b) begin
         q_reg <= b_in;
         q_1   <= 1'b0;
      end else if (shift_en) begin
         q_reg <= {acc[0], q_reg[W-1:1]};
         q_1   <= q_reg[0];
      end
      fp <= en_fp ? {acc[W-1:0], q_reg} : '0;
   end

   // Pair presented to the controller: look-ahead during LOAD/SHIFT
   logic [1:0] dp_pair;
   always_comb begin
      dp_pair = {q_reg[0], q_1};
      if (ld_b)          dp_pair = {b_in[0], 1'b0};
      else if (shift_en) dp_pair = q_reg[1:0];
   end

   logic alt_sel;
   always_ff @(posedge clk) begin
      if (ld_a)          alt_sel <= 1'b0;
      else if (shift_en) alt_sel <= ~alt_sel;
   end

   int         pmode;       // 0 datapath, 1 forced constant, 2 alternating 01/10
   logic [1:0] force_pair;
   always_comb begin
      case (pmode)
         0:       q0_q1 = dp_pair;
         1:       q0_q1 = force_pair;
         default: q0_q1 = alt_sel ? 2'b10 : 2'b01;
      endcase
   end

   // Scoreboard
   typedef struct {
      int             lat;
      int             n_add;
      int             n_sub;
      bit             chk_prod;
      logic [2*W-1:0] prod;
   } exp_t;

   exp_t sb[$];

   function automatic void booth_ops(input logic [W-1:0] b, output int adds, output int subs);
      logic prev;
      prev = 1'b0;
      adds = 0;
      subs = 0;
      for (int i = 0; i < W; i++) begin
         if ({b[i], prev} == 2'b01) adds++;
         else if ({b[i], prev} == 2'b10) subs++;
         prev = b[i];
      end
   endfunction

   function automatic int exp_lat(input int evals);
`ifdef BOOTH_SKIP_EN
      return W + 2 + evals;
`else
      return 2 * W + 2 + 0 * evals;
`endif
   endfunction

   task automatic expect_op(input int adds, input int subs, input bit chk, input logic [2*W-1:0] prod);
      exp_t e;
      e.lat      = exp_lat(adds + subs);
      e.n_add    = adds;
      e.n_sub    = subs;
      e.chk_prod = chk;
      e.prod     = prod;
      sb.push_back(e);
   endtask

   // Monitor: pops an expectation on every done pulse
   initial begin : monitor
      exp_t           e;
      int             t, na, ns, nsh;
      bit             in_op, bad, pend, pend_chk;
      logic [2*W-1:0] pend_prod;
      in_op = 1'b0; pend = 1'b0; bad = 1'b0; pend_chk = 1'b0; pend_prod = '0;
      t = 0; na = 0; ns = 0; nsh = 0;
      forever begin
         @(negedge clk);
         if (pend) begin
            pend = 1'b0;
            check("en_fp_after_done", int'(en_fp), 1);
            if (pend_chk) check("product", int'(fp), int'(pend_prod));
         end
         if (ld_a) begin
            in_op = 1'b1; t = 1; na = 0; ns = 0; nsh = 0; bad = 1'b0;
            check("en_fp_in_load", int'(en_fp), 0);
         end else if (in_op) begin
            t++;
         end
         if (in_op) begin
            if (add_en)   na++;
            if (sub_en)   ns++;
            if (shift_en) nsh++;
            if ((add_en && sub_en) || (shift_en && (add_en || sub_en)) || !busy) bad = 1'b1;
            if (done) begin
               in_op = 1'b0;
               if (sb.size() == 0) begin
                  check("unexpected_done", int'(done), 0);
               end else begin
                  e = sb.pop_front();
                  check("done_cycle", t, e.lat);
                  check("add_pulses", na, e.n_add);
                  check("sub_pulses", ns, e.n_sub);
                  check("shift_pulses", nsh, W);
                  check("overlap_or_busy_drop", int'(bad), 0);
                  pend      = 1'b1;
                  pend_chk  = e.chk_prod;
                  pend_prod = e.prod;
               end
            end
         end else if (done) begin
            check("unexpected_done", int'(done), 0);
         end
      end
   end

   task automatic run_op(input int mode, input logic [1:0] fpair, input logic [W-1:0] a, input logic [W-1:0] b);
      pmode      = mode;
      force_pair = fpair;
      a_in       = a;
      b_in       = b;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(name, int'(busy), 0);
   endtask

   logic [W-1:0]   va [7] = '{8'h03, 8'h80, 8'h7F, 8'h05, 8'hFF, 8'hF9, 8'h7F};
   logic [W-1:0]   vb [7] = '{8'hFE, 8'h80, 8'h00, 8'h07, 8'hFF, 8'h05, 8'h80};
   logic [2*W-1:0] vp [7] = '{16'hFFFA, 16'h4000, 16'h0000, 16'h0023, 16'h0001, 16'hFFDD, 16'hC080};

   initial begin : stimulus
      int ad, sn, k;
      reset = 1'b1; start = 1'b0; pmode = 1; force_pair = 2'b00; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset_idle_outputs", int'(outs), 0);
      end

      // q0_q1 tied 00 and 11: shifts only
      expect_op(0, 0, 1'b0, '0);
      run_op(1, 2'b00, '0, '0);
      wait_idle("busy_timeout_tied00");
      repeat (3) @(negedge clk);
      check("en_fp_held_idle", int'(en_fp), 1);
      expect_op(0, 0, 1'b0, '0);
      run_op(1, 2'b11, '0, '0);
      wait_idle("busy_timeout_tied11");

      // Alternating 01/10: four adds, four subtracts
      expect_op(4, 4, 1'b0, '0);
      run_op(2, 2'b00, '0, '0);
      wait_idle("busy_timeout_alt");

      // Real multiplies through the attached datapath
      for (int i = 0; i < 7; i++) begin
         booth_ops(vb[i], ad, sn);
         expect_op(ad, sn, 1'b1, vp[i]);
         run_op(0, 2'b00, va[i], vb[i]);
         wait_idle("busy_timeout_mul");
      end
      repeat (4) @(negedge clk);
      check("product_held", int'(fp), int'(vp[6]));

      // Start re-asserted mid-operation is ignored; product clears after LOAD
      expect_op(0, 0, 1'b0, '0);
      run_op(1, 2'b00, '0, '0);
      @(negedge clk);
      check("en_fp_drops_in_load", int'(en_fp), 0);
      @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check("fp_cleared_after_load", int'(fp), 0);
      repeat (6) @(posedge clk);
      #1 start = 1'b0;
      wait_idle("busy_timeout_restart_ignored");
      repeat (3) @(negedge clk);
      check("no_queued_request", int'(busy), 0);

      // Start held high: a new operation after exactly one IDLE cycle
      expect_op(0, 0, 1'b0, '0);
      expect_op(0, 0, 1'b0, '0);
      pmode = 1; force_pair = 2'b11;
      start = 1'b1;
      @(posedge clk);
      #1;
      wait_idle("busy_timeout_held_start");
      @(posedge clk);
      #1;
      check("held_start_reloads", int'(ld_a), 1);
      start = 1'b0;
      wait_idle("busy_timeout_held_second");

      // Reset in cycle 9 aborts the operation without a done pulse
      run_op(1, 2'b00, '0, '0);
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_abort_outputs", int'(outs), 0);
      check("reset_abort_fp", int'(fp), 0);
      repeat (30) @(negedge clk);
      check("reset_abort_stays_idle", int'(busy), 0);

      // Recovery after the abort
      booth_ops(8'hFE, ad, sn);
      expect_op(ad, sn, 1'b1, 16'hFFFA);
      run_op(0, 2'b00, 8'h03, 8'hFE);
      wait_idle("busy_timeout_recovery");

      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath. On a `start` request it loads the operands and clears the accumulator. It then runs `WIDTH_M` evaluate/shift iterations, steering add/subtract from the multiplier's low bit pair. Finally it enables the final-product register with `en_fp`. The block sits between the requesting logic and the datapath registers (accumulator, multiplier shift register, final product) and drives all of their enables.

## Interface
- `WIDTH_M`, default 16: operand width in bits and the Booth iteration count; legal range ≥ 2. The final product is `2*WIDTH_M` bits wide.
- `clk` input 1: the block's single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start` input 1: multiply request; sampled only in IDLE.
- `q0_q1` input 2: {Q0, Q-1} from the datapath multiplier register.
- `ld_a` output 1: load multiplicand register.
- `ld_b` output 1: load multiplier register and clear Q-1.
- `clr_acc` output 1: clear accumulator.
- `add_en` output 1: accumulator += multiplicand.
- `sub_en` output 1: accumulator -= multiplicand.
- `shift_en` output 1: arithmetic shift right of {acc, Q, Q-1}.
- `en_fp` output 1: final-product register enable; must be held high to keep the result.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- State register: IDLE, LOAD, EVAL, SHIFT, FIN. Iteration counter `cnt` is `$clog2(WIDTH_M+1)` bits wide. Result-valid flag `vld` is 1 bit.
- All outputs are decoded from the state register and `vld`. `add_en`/`sub_en` additionally decode `q0_q1` in EVAL.
- IDLE:
  - `en_fp` = `vld`.
  - If `start` is high, go to LOAD; otherwise stay in IDLE.
- LOAD:
  - Outputs: `ld_a` = `ld_b` = `clr_acc` = 1.
  - Actions: `cnt` ← `WIDTH_M`; `vld` ← 0.
  - `en_fp` falls here, so the final-product register clears to 0 at this edge.
  - Next state: EVAL.
- EVAL:
  - `q0_q1` = 2'b01: `add_en` = 1.
  - `q0_q1` = 2'b10: `sub_en` = 1.
  - `q0_q1` = 2'b00 or 2'b11: no operation.
  - Next state: SHIFT.
- SHIFT:
  - Output: `shift_en` = 1.
  - Action: `cnt` ← `cnt` − 1.
  - If `cnt` == 1, go to FIN; otherwise go to EVAL.
- FIN:
  - Outputs: `en_fp` = 1, `done` = 1.
  - Action: `vld` ← 1.
  - Next state: IDLE.
- After FIN, `en_fp` stays high in IDLE, because `vld` is set, until the next request is accepted.
- `add_en` and `sub_en` are never high together. `shift_en` is never high in the same cycle as `add_en` or `sub_en`.
- `start` in any state other than IDLE is ignored; requests are not queued.
- `start` held continuously high starts a new multiply on every return to IDLE, one IDLE cycle per operation.
- `reset` takes priority over every transition. On reset:
  - state ← IDLE, `cnt` ← 0, `vld` ← 0.
  - All outputs are 0 from the following cycle.
- Reset mid-operation therefore drops `en_fp`, which clears the product register, and no `done` is issued.

## Timing
- Reset value of every output: 0.
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- Without `BOOTH_SKIP_EN`:
  - LOAD: cycle 1.
  - EVAL/SHIFT pairs: cycles 2 … 2·`WIDTH_M`+1.
  - FIN: cycle 2·`WIDTH_M`+2.
  - For `WIDTH_M`=16, `done` is high in cycle 34 and the product is valid from the edge ending cycle 34.
- `busy` is high from cycle 1 through FIN inclusive.
- The next `start` can be accepted in the cycle after FIN, giving a throughput of one multiply per 2·`WIDTH_M`+3 cycles.
- `q0_q1` is sampled combinationally in EVAL; the datapath must present post-shift values by then.

## Configuration
- `BOOTH_SKIP_EN` defined:
  - In SHIFT with `cnt` > 1, the next state is SHIFT (not EVAL) when the next pair is 2'b00 or 2'b11.
  - Likewise, LOAD goes directly to SHIFT when `q0_q1` is 2'b00 or 2'b11.
  - The datapath presents the next pair on its `q0_q1` output during SHIFT.
  - Latency is variable: `WIDTH_M`+2 cycles minimum, 2·`WIDTH_M`+2 maximum.
  - Counting and FIN behaviour are unchanged.
- `BOOTH_SKIP_EN` undefined: every iteration takes one EVAL and one SHIFT cycle, giving fixed latency.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `busy` 0, `en_fp` 0.
- `WIDTH_M`=8, `start` pulse, `q0_q1` tied 2'b00:
  - `ld_a`/`ld_b`/`clr_acc` high in cycle 1.
  - Exactly 8 `shift_en` pulses, with `add_en`/`sub_en` never high.
  - `done` high in cycle 18; `en_fp` high from cycle 18 and held.
- With the datapath attached, `WIDTH_M`=8: 3 × −2 → product 16'hFFFA; −128 × −128 → 16'h4000; 127 × 0 → 16'h0000.
- Alternating `q0_q1` 01/10 → 4 `add_en` and 4 `sub_en` pulses, each in EVAL only, never overlapping `shift_en`.
- Boundary conditions:
  - `start` re-asserted during cycles 2–17 → ignored, single `done` pulse.
  - `reset` asserted in cycle 9 → IDLE next cycle, `en_fp` 0, no `done`.
  - New `start` after completion → `en_fp` drops in LOAD.
- `BOOTH_SKIP_EN` defined, `q0_q1` tied 2'b11, `WIDTH_M`=8 → no EVAL cycles, `done` in cycle 10; pattern 01,00,… → one EVAL cycle only.
